// File: rtl/rx_pkg.sv
// Shared FSM state type, length defaults and byte-enable popcount for the
// rx frame length checker.
package rx_pkg;

  localparam int LEN_W_DEF     = 16;
  localparam int MIN_LEN_DEF   = 64;
  localparam int MAX_LEN_DEF   = 1518;
  localparam int JUMBO_LEN_DEF = 9018;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } rx_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] be);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, be[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rx_frame_len_check_if.sv
// Word stream from the byte-lane decoder plus the length/status pulse
// handed to the statistics counters.
interface rx_frame_len_check_if
  import rx_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);
  logic             rx_valid;
  logic             rx_sof;
  logic             rx_eof;
  logic [7:0]       rx_be;
  logic [LEN_W-1:0] frame_len;
  logic             stat_vld;
  logic             too_short;
  logic             too_long;
  logic             aborted;

  modport master (
    output rx_valid, rx_sof, rx_eof, rx_be,
    input  frame_len, stat_vld, too_short, too_long, aborted
  );

  modport slave (
    input  rx_valid, rx_sof, rx_eof, rx_be,
    output frame_len, stat_vld, too_short, too_long, aborted
  );
endinterface

// File: rtl/rx_len_acc.sv
// Saturating byte accumulator: load restarts the count, add accumulates,
// otherwise hold. sum_o is the saturated acc + bytes_i for end-of-frame use.
module rx_len_acc #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             add_i,
  input  logic [3:0]       bytes_i,
  output logic [LEN_W-1:0] acc_o,
  output logic [LEN_W-1:0] sum_o
);

  logic [LEN_W-1:0] acc_q;
  logic [LEN_W-1:0] acc_d;
  logic [LEN_W:0]   wide_s;

  // Next count; a carry out clamps the sum at all-ones instead of wrapping.
  always_comb begin
    wide_s = {1'b0, acc_q} + {{(LEN_W-3){1'b0}}, bytes_i};
    if (wide_s[LEN_W]) begin
      sum_o = {LEN_W{1'b1}};
    end else begin
      sum_o = wide_s[LEN_W-1:0];
    end
    if (load_i) begin
      acc_d = {{(LEN_W-4){1'b0}}, bytes_i};
    end else if (add_i) begin
      acc_d = sum_o;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= {LEN_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/rx_frame_len_check.sv
// Per-frame byte counter issuing a one-cycle length/runt/oversize/abort pulse.
// Define RX_JUMBO_EN to raise the oversize limit from MAX_LEN to JUMBO_LEN.
module rx_frame_len_check
  import rx_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int MIN_LEN   = MIN_LEN_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int JUMBO_LEN = JUMBO_LEN_DEF
) (
  input logic                 clk,
  input logic                 reset,
  rx_frame_len_check_if.slave rx_if
);

`ifdef RX_JUMBO_EN
  localparam int ACT_MAX = (JUMBO_LEN > MAX_LEN) ? JUMBO_LEN : MAX_LEN;
`else
  localparam int ACT_MAX = (MAX_LEN < JUMBO_LEN) ? MAX_LEN : JUMBO_LEN;
`endif
  localparam logic [LEN_W-1:0] LEN_SAT = {LEN_W{1'b1}};

  rx_state_e        state_q;
  logic [3:0]       pop_s;
  logic [LEN_W-1:0] pop_len_s;
  logic [LEN_W-1:0] acc_s;
  logic [LEN_W-1:0] sum_s;
  logic             load_s;
  logic             add_s;
  logic             ev_s;
  logic             ev_abort_s;
  logic [LEN_W-1:0] ev_len_s;
  logic             ev2_s;
  logic             pend_q;
  logic             pend_abort_q;
  logic [LEN_W-1:0] pend_len_q;
  logic             out_vld_s;
  logic             out_abort_s;
  logic [LEN_W-1:0] out_len_s;
  logic             short_s;
  logic             long_s;
  logic [LEN_W-1:0] frame_len_q;
  logic             stat_vld_q;
  logic             too_short_q;
  logic             too_long_q;
  logic             aborted_q;

  assign pop_s     = popcount8(rx_if.rx_be);
  assign pop_len_s = {{(LEN_W-4){1'b0}}, pop_s};

  rx_len_acc #(.LEN_W(LEN_W)) u_acc (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_s),
    .add_i   (add_s),
    .bytes_i (pop_s),
    .acc_o   (acc_s),
    .sum_o   (sum_s)
  );

  // Word decode: accumulator controls and the status events this word raises.
  // A sof inside a frame can raise two: the abort, then a single-word frame.
  always_comb begin
    load_s     = 1'b0;
    add_s      = 1'b0;
    ev_s       = 1'b0;
    ev_abort_s = 1'b0;
    ev_len_s   = sum_s;
    ev2_s      = 1'b0;
    if (rx_if.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_if.rx_sof) begin
            ev_s     = rx_if.rx_eof;
            ev_len_s = pop_len_s;
            load_s   = ~rx_if.rx_eof;
          end else begin
            ev_s = 1'b0;
          end
        end
        COUNT: begin
          if (rx_if.rx_sof) begin
            ev_s       = 1'b1;
            ev_abort_s = 1'b1;
            ev_len_s   = acc_s;
            ev2_s      = rx_if.rx_eof;
            load_s     = ~rx_if.rx_eof;
          end else begin
            add_s    = 1'b1;
            ev_s     = rx_if.rx_eof;
            ev_len_s = sum_s;
          end
        end
        default: begin
          ev_s = 1'b0;
        end
      endcase
    end else begin
      ev_s = 1'b0;
    end
  end

  // A deferred status goes out ahead of anything raised this cycle.
  always_comb begin
    if (pend_q) begin
      out_vld_s   = 1'b1;
      out_len_s   = pend_len_q;
      out_abort_s = pend_abort_q;
    end else begin
      out_vld_s   = ev_s;
      out_len_s   = ev_len_s;
      out_abort_s = ev_abort_s;
    end
    short_s = 32'(out_len_s) < MIN_LEN;
    long_s  = (32'(out_len_s) > ACT_MAX) || (out_len_s == LEN_SAT);
  end

  // FSM, deferred status slot and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_abort_q <= 1'b0;
      pend_len_q   <= {LEN_W{1'b0}};
      frame_len_q  <= {LEN_W{1'b0}};
      stat_vld_q   <= 1'b0;
      too_short_q  <= 1'b0;
      too_long_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      if (rx_if.rx_valid) begin
        case (state_q)
          IDLE:    state_q <= (rx_if.rx_sof && !rx_if.rx_eof) ? COUNT : IDLE;
          COUNT:   state_q <= rx_if.rx_eof ? IDLE : COUNT;
          default: state_q <= IDLE;
        endcase
      end else begin
        state_q <= state_q;
      end
      pend_q       <= ev2_s | (pend_q & ev_s);
      pend_len_q   <= ev2_s ? pop_len_s : ev_len_s;
      pend_abort_q <= ev2_s ? 1'b0 : ev_abort_s;
      stat_vld_q   <= out_vld_s;
      if (out_vld_s) begin
        frame_len_q <= out_len_s;
        too_short_q <= short_s;
        too_long_q  <= long_s;
        aborted_q   <= out_abort_s;
      end else begin
        frame_len_q <= frame_len_q;
        too_short_q <= 1'b0;
        too_long_q  <= 1'b0;
        aborted_q   <= 1'b0;
      end
    end
  end

  assign rx_if.frame_len = frame_len_q;
  assign rx_if.stat_vld  = stat_vld_q;
  assign rx_if.too_short = too_short_q;
  assign rx_if.too_long  = too_long_q;
  assign rx_if.aborted   = aborted_q;

endmodule

// File: tb/tb_rx_frame_len_check.sv
// Bench for rx_frame_len_check: directed frame table, multi-cycle corner
// sequences and random frames scored against a frame-level length model.
`timescale 1ns/1ps
module tb_rx_frame_len_check;

`ifdef RX_JUMBO_EN
  localparam int ACT_MAX = 9018;
`else
  localparam int ACT_MAX = 1518;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_frame_len_check_if #(.LEN_W(16)) b16 ();
  rx_frame_len_check_if #(.LEN_W(8))  b8 ();

  rx_frame_len_check #(.LEN_W(16)) dut16 (.clk(clk), .reset(reset), .rx_if(b16.slave));
  rx_frame_len_check #(.LEN_W(8))  dut8  (.clk(clk), .reset(reset), .rx_if(b8.slave));

  typedef struct {
    int len;
    bit sh;
    bit lg;
    bit ab;
    int cyc;
  } stat_t;

  typedef struct {
    string      name;
    int         n;
    logic [7:0] last_be;
    int         gap_at;
    int         gap_len;
    int         len;
    bit         sh;
    bit         lg;
  } vec_t;

  stat_t exp16[$];
  stat_t exp8[$];
  vec_t  vecs[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  // Frame-level expectation: saturate the byte total, then apply the limits.
  function automatic stat_t model(input int total, input int w, input bit ab, input int at);
    stat_t s;
    int    sat;
    sat   = (1 << w) - 1;
    s.len = (total >= sat) ? sat : total;
    s.sh  = s.len < 64;
    s.lg  = (s.len > ACT_MAX) || (s.len == sat);
    s.ab  = ab;
    s.cyc = at;
    return s;
  endfunction

  task automatic check_port(input string nm, input bit sel, input bit vld, input int len,
                            input bit sh, input bit lg, input bit ab);
    stat_t e;
    bit    have;
    have = 1'b0;
    for (int guard = 0; guard < 4; guard++) begin
      have = sel ? (exp8.size() > 0) : (exp16.size() > 0);
      if (have) e = sel ? exp8[0] : exp16[0];
      if (!have || e.cyc >= cyc) break;
      checks++;
      errors++;
      $display("FAIL %s missing_pulse: got no stat_vld, want len=%0d at cycle %0d", nm, e.len, e.cyc);
      if (sel) void'(exp8.pop_front()); else void'(exp16.pop_front());
      have = 1'b0;
    end
    checks++;
    if (vld) begin
      if (have && e.cyc == cyc) begin
        if (sel) void'(exp8.pop_front()); else void'(exp16.pop_front());
        if (len != e.len || sh != e.sh || lg != e.lg || ab != e.ab) begin
          errors++;
          $display("FAIL %s stat: got len=%0d short=%0b long=%0b abort=%0b, want len=%0d short=%0b long=%0b abort=%0b (cycle %0d)",
                   nm, len, sh, lg, ab, e.len, e.sh, e.lg, e.ab, cyc);
        end
      end else begin
        errors++;
        $display("FAIL %s unexpected_pulse: got len=%0d at cycle %0d, want no stat_vld", nm, len, cyc);
      end
    end else if (sh | lg | ab) begin
      errors++;
      $display("FAIL %s idle_flags: got short=%0b long=%0b abort=%0b, want 0 without stat_vld", nm, sh, lg, ab);
    end
  endtask

  // One clock: sample both DUTs at the falling edge, then drive the next word.
  task automatic tick(input bit v, input bit s, input bit e, input logic [7:0] be, input bit to8);
    @(negedge clk);
    cyc++;
    check_port("len16", 1'b0, b16.stat_vld, int'(b16.frame_len), b16.too_short, b16.too_long, b16.aborted);
    check_port("len8", 1'b1, b8.stat_vld, int'(b8.frame_len), b8.too_short, b8.too_long, b8.aborted);
    b16.rx_valid = v;
    b16.rx_sof   = s;
    b16.rx_eof   = e;
    b16.rx_be    = be;
    b8.rx_valid  = v & to8;
    b8.rx_sof    = s;
    b8.rx_eof    = e;
    b8.rx_be     = be;
  endtask

  // Idle cycle with junk on the qualified fields.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] last_be, input int gap_at, input int gap_len,
                            input bit to8, output int eof_cyc, output int total);
    logic [7:0] be;
    total   = 0;
    eof_cyc = 0;
    for (int i = 0; i < n; i++) begin
      be = (i == n - 1) ? last_be : 8'hFF;
      tick(1'b1, i == 0, i == n - 1, be, to8);
      total += $countones(be);
      if (i == n - 1) eof_cyc = cyc;
      if (i == gap_at) idle(gap_len);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    int         ec;
    int         tot;
    int         pend_abort;
    int         n;
    int         k;
    bit         do_abort;
    bit         last;
    bit         abort_pushed;
    logic [7:0] be;

    reset = 1'b1;
    b16.rx_valid = 1'b0; b16.rx_sof = 1'b0; b16.rx_eof = 1'b0; b16.rx_be = 8'h00;
    b8.rx_valid  = 1'b0; b8.rx_sof  = 1'b0; b8.rx_eof  = 1'b0; b8.rx_be  = 8'h00;
    idle(3);
    chk("rst_frame_len", int'(b16.frame_len), 0);
    chk("rst_stat_vld", int'(b16.stat_vld), 0);
    chk("rst_flags", int'({b16.too_short, b16.too_long, b16.aborted}), 0);
    reset = 1'b0;
    idle(2);

    vecs.push_back('{"t1_60B",      8,    8'h0F, -1, 0, 60,   1'b1, 1'b0});
    vecs.push_back('{"t2_64B",      8,    8'hFF, -1, 0, 64,   1'b0, 1'b0});
    vecs.push_back('{"t2_63B",      8,    8'h7F, -1, 0, 63,   1'b1, 1'b0});
    vecs.push_back('{"single_8B",   1,    8'hFF, -1, 0, 8,    1'b1, 1'b0});
    vecs.push_back('{"t5_gap_100B", 13,   8'h0F, 4,  5, 100,  1'b0, 1'b0});
    vecs.push_back('{"t3_1518B",    190,  8'h3F, -1, 0, 1518, 1'b0, 1'b0});
    vecs.push_back('{"t3_1519B",    190,  8'h7F, -1, 0, 1519, 1'b0, (ACT_MAX < 1519)});
    vecs.push_back('{"t3_9018B",    1128, 8'h03, -1, 0, 9018, 1'b0, (ACT_MAX < 9018)});
    vecs.push_back('{"t3_9019B",    1128, 8'h07, -1, 0, 9019, 1'b0, 1'b1});
    foreach (vecs[i]) begin
      send_frame(vecs[i].n, vecs[i].last_be, vecs[i].gap_at, vecs[i].gap_len, 1'b0, ec, tot);
      exp16.push_back('{vecs[i].len, vecs[i].sh, vecs[i].lg, 1'b0, ec + 1});
      idle(2);
    end

    // Abort by a sof+eof word: abort pulse, then the single-word frame's pulse.
    for (int i = 0; i < 20; i++) tick(1'b1, i == 0, 1'b0, 8'hFF, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 8'h3F, 1'b0);
    exp16.push_back('{160, 1'b0, 1'b0, 1'b1, cyc + 1});
    exp16.push_back('{6, 1'b1, 1'b0, 1'b0, cyc + 2});
    idle(3);

    // Words without sof while idle raise nothing.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, i == 2, 8'hFF, 1'b0);
    idle(2);

    // Reset mid-frame drops the frame; the next frame counts from scratch.
    for (int i = 0; i < 4; i++) tick(1'b1, i == 0, 1'b0, 8'hFF, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    send_frame(8, 8'hFF, -1, 0, 1'b0, ec, tot);
    exp16.push_back('{64, 1'b0, 1'b0, 1'b0, ec + 1});
    idle(2);

    // 300 bytes into both widths: the 8-bit counter pins at 255.
    send_frame(38, 8'h0F, -1, 0, 1'b1, ec, tot);
    exp16.push_back('{300, 1'b0, 1'b0, 1'b0, ec + 1});
    exp8.push_back('{255, 1'b0, 1'b1, 1'b0, ec + 1});
    idle(2);

    pend_abort = -1;
    for (int r = 0; r < 60; r++) begin
      if (pend_abort < 0 && $urandom_range(0, 3) == 0) begin
        tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
      end
      n            = ($urandom_range(0, 4) == 0) ? $urandom_range(180, 200) : $urandom_range(1, 40);
      do_abort     = ($urandom_range(0, 5) == 0);
      k            = do_abort ? $urandom_range(1, n) : n;
      tot          = 0;
      abort_pushed = 1'b0;
      for (int i = 0; i < k; i++) begin
        last = !do_abort && (i == n - 1);
        be   = last ? 8'($urandom_range(0, 255)) : 8'hFF;
        tick(1'b1, i == 0, last, be, 1'b0);
        tot += $countones(be);
        if (i == 0 && pend_abort >= 0) begin
          exp16.push_back(model(pend_abort, 16, 1'b1, cyc + 1));
          pend_abort   = -1;
          abort_pushed = 1'b1;
        end
        if (last) exp16.push_back(model(tot, 16, 1'b0, cyc + 1 + int'(abort_pushed && i == 0)));
        if (!last && $urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      end
      if (do_abort) pend_abort = tot;
      else idle($urandom_range(1, 2));
    end
    if (pend_abort >= 0) begin
      tick(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
      exp16.push_back(model(pend_abort, 16, 1'b1, cyc + 1));
      exp16.push_back(model(8, 16, 1'b0, cyc + 2));
    end
    idle(10);
    chk("leftover_expected", exp16.size() + exp8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
